// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared constants and state encoding for the sequential multiplier
package mult_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/half_adder.sv
// rtl/half_adder.sv - one-bit half adder cell
module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b;
  assign o_carry = i_a & i_b;

endmodule

// File: rtl/ripple_adder.sv
// rtl/ripple_adder.sv - N-bit ripple-carry adder built from half-adder based full adders
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_adder u_ha0 (.i_a(i_a),  .i_b(i_b),   .o_sum(w_s1),  .o_carry(w_c1));
  half_adder u_ha1 (.i_a(w_s1), .i_b(i_cin), .o_sum(o_sum), .o_carry(w_c2));

  assign o_cout = w_c1 | w_c2;

endmodule

module ripple_adder #(
  parameter int N = 16
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum,
  output logic         o_cout
);

  logic [N:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar g = 0; g < N; g++) begin : g_bit
    full_adder u_fa (
      .i_a   (i_a[g]),
      .i_b   (i_b[g]),
      .i_cin (w_c[g]),
      .o_sum (o_sum[g]),
      .o_cout(w_c[g+1])
    );
  end

  assign o_cout = w_c[N];

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-and-add unsigned multiplier, one partial product per clock
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  state_t               r_state;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_p;
  logic                 r_busy;
  logic                 r_done;

  logic [2*WIDTH-1:0]   w_addend;
  logic [2*WIDTH-1:0]   w_sum;
  logic                 w_cout;
  logic                 w_last;

  // Partial product is either the shifted multiplicand or nothing.
  assign w_addend = r_mplier[0] ? r_mcand : '0;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  ripple_adder #(.N(2 * WIDTH)) u_adder (
    .i_a   (r_acc),
    .i_b   (w_addend),
    .i_cin (1'b0),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  // Control FSM with datapath registers; busy/done/P are registered alongside state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_p      <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_mcand  <= {{WIDTH{1'b0}}, A};
            r_mplier <= B;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_p     <= w_sum;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The running sum never exceeds the final product, so the adder never carries out.
  always_ff @(posedge clk) begin
    if (!rst && r_state == S_RUN) begin
      assert (!w_cout);
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign P    = r_p;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier at WIDTH=4
module tb_seq_multiplier;

  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*W-1:0] P;

  int n_checks;
  int n_pass;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .P    (P)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation; the model: busy for W cycles after the accepting edge,
  // then a single done cycle carrying a*b, then idle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit full);
    int exp_p;
    int n_done;
    exp_p  = int'(a) * int'(b);
    n_done = 0;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    step();
    start = 1'b0;
    A = W'($urandom);
    B = W'($urandom);
    for (int i = 1; i <= W; i++) begin
      if (full) begin
        check("busy_run", busy, 1);
        check("done_run", done, 0);
      end
      if (done) n_done++;
      step();
    end
    check("done_pulse", done, 1);
    check("product", P, exp_p);
    if (full) check("busy_done", busy, 0);
    step();
    check("done_single", done, 0);
    if (full) check("p_hold", P, exp_p);
    check("no_early_done", n_done, 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_p", P, 0);
    @(negedge clk);
    rst = 1'b0;

    // directed cases
    run_op(4'd13, 4'd11, 1'b1);
    run_op(4'd15, 4'd15, 1'b1);
    run_op(4'd0, 4'd9, 1'b1);
    run_op(4'd9, 4'd0, 1'b1);

    // exhaustive sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(W'(a), W'(b), 1'b0);

    // random operands with full latency checking
    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), 1'b1);

    // back-to-back: start held high through DONE
    @(negedge clk);
    A = 4'd3; B = 4'd5; start = 1'b1;
    step();
    A = 4'd7; B = 4'd6;
    for (int i = 1; i <= W; i++) begin
      check("b2b_busy1", busy, 1);
      step();
    end
    check("b2b_done1", done, 1);
    check("b2b_p1", P, 15);
    step();
    start = 1'b0;
    check("b2b_no_idle", busy, 1);
    check("b2b_gap_done", done, 0);
    for (int i = 2; i <= W; i++) begin
      check("b2b_done_quiet", done, 0);
      step();
    end
    step();
    check("b2b_done2", done, 1);
    check("b2b_p2", P, 42);
    step();
    check("b2b_end", done, 0);

    // start while busy is ignored
    @(negedge clk);
    A = 4'd12; B = 4'd7; start = 1'b1;
    step();
    start = 1'b0;
    step();
    A = 4'd1; B = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    check("ign_done", done, 1);
    check("ign_p", P, 84);
    step();
    check("ign_no_extra_done", done, 0);
    check("ign_idle", busy, 0);
    for (int i = 0; i < W + 2; i++) begin
      check("ign_quiet", done, 0);
      step();
    end

    // reset mid-operation
    @(negedge clk);
    A = 4'd9; B = 4'd9; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_p", P, 0);
    rst = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      check("abort_no_done", done, 0);
      step();
    end

    // reset and start on the same edge: reset wins
    @(negedge clk);
    rst = 1'b1; A = 4'd5; B = 4'd5; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);

    run_op(4'd2, 4'd3, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
